// File: rtl/mult_div_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    function automatic logic is_signed_op(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO pair: one shift-add or
// restoring-subtract step per cycle on operand magnitudes, sign fix-up at the end.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_N,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Write_HI,
    input  logic             Write_LO,
    input  logic [WIDTH-1:0] Write_Data,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done
);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, done_q;

    op_e                  start_op;
    logic                 start_signed;
    logic [WIDTH-1:0]     abs_a, abs_b;

    logic [WIDTH:0]       alu_x, alu_y;
    logic [WIDTH+1:0]     alu_r;
    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign start_op     = op_e'(Op);
    assign start_signed = is_signed_op(start_op);
    assign abs_a        = (start_signed && Operand_A[WIDTH-1]) ? -Operand_A : Operand_A;
    assign abs_b        = (start_signed && Operand_B[WIDTH-1]) ? -Operand_B : Operand_B;

    // One adder/subtractor serves both: multiply adds the multiplicand to the
    // upper word, divide subtracts the divisor from the shifted partial remainder.
    assign alu_x = is_div_op(op_q) ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign alu_y = {1'b0, opnd_q};
    assign alu_r = is_div_op(op_q) ? ({1'b0, alu_x} - {1'b0, alu_y})
                                   : ({1'b0, alu_x} + {1'b0, alu_y});

    always_comb begin
        if (is_div_op(op_q)) begin
            if (!alu_r[WIDTH+1]) begin
                step_acc = {alu_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            step_acc = {alu_r[WIDTH:0], acc_q[WIDTH-1:1]};
        end else begin
            step_acc = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // A zero divisor leaves the dividend magnitude as remainder, so the usual
    // remainder sign fix already restores the original dividend for HI.
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (opnd_q == '0)        ? '1
                    : (neg_a_q ^ neg_b_q)   ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = CALC;
                    op_d    = start_op;
                    neg_a_d = start_signed & Operand_A[WIDTH-1];
                    neg_b_d = start_signed & Operand_B[WIDTH-1];
                    cnt_d   = '0;
                    if (is_div_op(start_op)) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end else begin
                    if (Write_HI) hi_d = Write_Data;
                    if (Write_LO) lo_d = Write_Data;
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERATIONS - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                if (is_div_op(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == FIX);
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model compared every
// cycle, directed corner cases with literal expectations, then randomized traffic.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] Operand_A = '0;
    logic [31:0] Operand_B = '0;
    logic        Write_HI = 1'b0;
    logic        Write_LO = 1'b0;
    logic [31:0] Write_Data = '0;
    logic [31:0] HI, LO;
    logic        Busy, Done;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clock      (Clock),
        .Reset_N    (Reset_N),
        .Start      (Start),
        .Op         (Op),
        .Operand_A  (Operand_A),
        .Operand_B  (Operand_B),
        .Write_HI   (Write_HI),
        .Write_LO   (Write_LO),
        .Write_Data (Write_Data),
        .HI         (HI),
        .LO         (LO),
        .Busy       (Busy),
        .Done       (Done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Architectural result as {HI, LO}, straight from integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0)                                 r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    r[31:0]  = 32'(sa / sb);
                    r[63:32] = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Model: an accepted Start makes the unit busy for 33 edges, then results land with Done.
    int unsigned remaining = 0;
    logic [63:0] pend = '0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;

    always @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            remaining <= 0;
            m_hi      <= '0;
            m_lo      <= '0;
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (remaining != 0) begin
                remaining <= remaining - 1;
                if (remaining == 1) begin
                    m_hi   <= pend[63:32];
                    m_lo   <= pend[31:0];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (Start) begin
                pend      <= ref_result(Op, Operand_A, Operand_B);
                remaining <= 33;
                m_busy    <= 1'b1;
            end else begin
                if (Write_HI) m_hi <= Write_Data;
                if (Write_LO) m_lo <= Write_Data;
            end
        end
    end

    always @(negedge Clock) begin
        if (Reset_N) begin
            check("model_hi",   64'(HI),   64'(m_hi));
            check("model_lo",   64'(LO),   64'(m_lo));
            check("model_busy", 64'(Busy), 64'(m_busy));
            check("model_done", 64'(Done), 64'(m_done));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the Start edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start     = 1'b1;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        @(posedge Clock); #1;
        Start = 1'b0;
    endtask

    // Counts edges since Start was raised until Done is seen, bounded.
    task automatic wait_done(input int start_cnt, output int lat);
        lat = start_cnt;
        while (Done !== 1'b1 && lat < 200) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        launch(op, a, b);
        wait_done(1, lat);
        check({name, "_latency"}, 64'(lat), 64'd34);
        check({name, "_hi"}, 64'(HI), 64'(exp_hi));
        check({name, "_lo"}, 64'(LO), 64'(exp_lo));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int done_seen;

        repeat (2) @(posedge Clock);
        #1 Reset_N = 1'b1;
        check("rst_hi",   64'(HI),   64'd0);
        check("rst_lo",   64'(LO),   64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);

        // Both strobes load both registers, then an idle reset clears them.
        Write_HI = 1'b1; Write_LO = 1'b1; Write_Data = 32'hDEAD_BEEF;
        @(posedge Clock); #1;
        Write_HI = 1'b0; Write_LO = 1'b0;
        check("mt_both_hi", 64'(HI), 64'hDEAD_BEEF);
        check("mt_both_lo", 64'(LO), 64'hDEAD_BEEF);
        Reset_N = 1'b0; #1;
        check("idle_rst_hi",   64'(HI),   64'd0);
        check("idle_rst_lo",   64'(LO),   64'd0);
        check("idle_rst_busy", 64'(Busy), 64'd0);
        check("idle_rst_done", 64'(Done), 64'd0);
        @(posedge Clock); #1 Reset_N = 1'b1;

        Write_LO = 1'b1; Write_Data = 32'h0000_1234;
        @(posedge Clock); #1;
        Write_LO = 1'b0;
        check("mtlo_lo", 64'(LO), 64'h1234);
        check("mtlo_hi", 64'(HI), 64'd0);

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_neg",  OP_MULT,  -32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op("div_neg",   OP_DIV,   -32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu_zero", OP_DIVU,  32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        do_op("div_zero",  OP_DIV,   -32'd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        do_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Start and MTHI at CALC cycle 10 must be ignored.
        launch(OP_MULTU, 32'd1000, 32'd3);
        repeat (10) begin @(posedge Clock); #1; end
        Start = 1'b1; Op = OP_DIV; Operand_A = 32'd1; Write_HI = 1'b1; Write_Data = 32'hABCD;
        @(posedge Clock); #1;
        Start = 1'b0; Write_HI = 1'b0;
        wait_done(12, lat);
        check("busy_ign_latency", 64'(lat), 64'd34);
        check("busy_ign_hi", 64'(HI), 64'd0);
        check("busy_ign_lo", 64'(LO), 64'd3000);

        // Start with MTHI in the same idle cycle: the write is dropped.
        Write_HI = 1'b1; Write_Data = 32'h5555_5555;
        launch(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
        Write_HI = 1'b0;
        check("start_wins_hold", 64'(HI), 64'd0);
        wait_done(1, lat);
        check("start_wins_latency", 64'(lat), 64'd34);
        check("start_wins_hi", 64'(HI), 64'h0000_0003);
        check("start_wins_lo", 64'(LO), 64'h0000_0000);

        // Reset at CALC cycle 10 aborts with no Done, then a fresh op completes.
        Write_LO = 1'b1; Write_Data = 32'h0BAD_F00D;
        @(posedge Clock); #1;
        Write_LO = 1'b0;
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (10) begin @(posedge Clock); #1; end
        Reset_N = 1'b0; #1;
        check("mid_rst_busy", 64'(Busy), 64'd0);
        check("mid_rst_hi",   64'(HI),   64'd0);
        check("mid_rst_lo",   64'(LO),   64'd0);
        check("mid_rst_done", 64'(Done), 64'd0);
        @(posedge Clock); #1 Reset_N = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge Clock); #1;
            if (Done === 1'b1) done_seen++;
        end
        check("mid_rst_no_done", 64'(done_seen), 64'd0);
        do_op("after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Randomized traffic, including Starts and writes during Busy and on Done.
        for (int i = 0; i < 2500; i++) begin
            Start      = ($urandom_range(0, 4) == 0);
            Op         = 2'($urandom_range(0, 3));
            Operand_A  = rand_operand();
            Operand_B  = rand_operand();
            Write_HI   = ($urandom_range(0, 5) == 0);
            Write_LO   = ($urandom_range(0, 5) == 0);
            Write_Data = $urandom;
            @(posedge Clock); #1;
        end
        Start = 1'b0; Write_HI = 1'b0; Write_LO = 1'b0;
        repeat (40) begin @(posedge Clock); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
